// File: rtl/beta_trap_sequencer.sv
// Trap entry/return sequencer: stalls fetch, drains for interrupts, pulses the CSR
// commit and flush, then hands the trap/MRET target to fetch over valid/ready.
module beta_trap_sequencer #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned DrainTimeout = 16,
  parameter int unsigned BlankCycles  = 2,
  parameter int unsigned CountWidth   = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [1:0]            seq_trap_detected_i,
  input  logic                  seq_is_mret_i,
  input  logic [DataWidth-1:0]  seq_trap_address_i,
  input  logic [DataWidth-1:0]  seq_mepc_i,
  input  logic                  seq_pipe_idle_i,
  input  logic                  seq_redirect_ready_i,
  output logic                  seq_stall_o,
  output logic                  seq_flush_o,
  output logic                  seq_csr_we_o,
  output logic                  seq_redirect_valid_o,
  output logic [DataWidth-1:0]  seq_redirect_addr_o,
  output logic                  seq_busy_o,
  output logic                  seq_halt_o,
  output logic [CountWidth-1:0] seq_trap_count_o
);

  localparam int unsigned DrainW = $clog2(DrainTimeout);
  localparam int unsigned BlankW = (BlankCycles > 0) ? $clog2(BlankCycles + 1) : 1;

  localparam logic [DrainW-1:0]     DrainLast = DrainW'(DrainTimeout - 1);
  localparam logic [BlankW-1:0]     BlankLoad = BlankW'(BlankCycles);
  localparam logic [CountWidth-1:0] CountMax  = '1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_COMMIT   = 3'd2,
    ST_REDIRECT = 3'd3,
    ST_HALT     = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [DrainW-1:0]       drain_q, drain_d;
  logic [BlankW-1:0]       blank_q, blank_d;
  logic [DataWidth-1:0]    target_d;
  logic [CountWidth-1:0]   count_d;
  logic [DataWidth-1:0]    exc_target;
  logic                    exc_req;
  logic                    irq_req;

  // An exception/MRET request always wins over a concurrent interrupt.
  assign exc_req    = seq_trap_detected_i[1];
  assign irq_req    = seq_trap_detected_i[0];
  assign exc_target = seq_is_mret_i ? seq_mepc_i : seq_trap_address_i;

  // Next-state and next-value decode
  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    target_d = seq_redirect_addr_o;
    count_d  = seq_trap_count_o;
    blank_d  = (blank_q != '0) ? blank_q - BlankW'(1) : '0;

    unique case (state_q)
      ST_IDLE: begin
        if (exc_req) begin
          target_d = exc_target;
          state_d  = ST_COMMIT;
        end else if (irq_req && (blank_q == '0)) begin
          drain_d = '0;
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (exc_req) begin
          target_d = exc_target;
          state_d  = ST_COMMIT;
        end else if (seq_pipe_idle_i) begin
          target_d = seq_trap_address_i;
          state_d  = ST_COMMIT;
        end else if (!irq_req) begin
          state_d = ST_IDLE;
        end else if (drain_q == DrainLast) begin
          state_d = ST_HALT;
        end else begin
          drain_d = drain_q + DrainW'(1);
        end
      end

      ST_COMMIT: begin
        state_d = ST_REDIRECT;
      end

      ST_REDIRECT: begin
        if (seq_redirect_ready_i && seq_redirect_valid_o) begin
          state_d = ST_IDLE;
          blank_d = BlankLoad;
          if (seq_trap_count_o != CountMax) begin
            count_d = seq_trap_count_o + CountWidth'(1);
          end
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs decoded from the next state
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q              <= ST_IDLE;
      drain_q              <= '0;
      blank_q              <= '0;
      seq_stall_o          <= 1'b0;
      seq_flush_o          <= 1'b0;
      seq_csr_we_o         <= 1'b0;
      seq_redirect_valid_o <= 1'b0;
      seq_redirect_addr_o  <= '0;
      seq_busy_o           <= 1'b0;
      seq_halt_o           <= 1'b0;
      seq_trap_count_o     <= '0;
    end else begin
      state_q              <= state_d;
      drain_q              <= drain_d;
      blank_q              <= blank_d;
      seq_stall_o          <= (state_d != ST_IDLE);
      seq_busy_o           <= (state_d != ST_IDLE);
      seq_flush_o          <= (state_d == ST_COMMIT);
      seq_csr_we_o         <= (state_d == ST_COMMIT);
      seq_redirect_valid_o <= (state_d == ST_REDIRECT);
      seq_halt_o           <= (state_d == ST_HALT);
      seq_redirect_addr_o  <= target_d;
      seq_trap_count_o     <= count_d;
    end
  end

endmodule
